// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, fetch FSM state encoding and
// the width of the optional fetch counter (FETCH_CNT_EN).
package cpu_pkg;

  localparam int ADDR_W      = 8;
  localparam int DATA_W      = 8;
  localparam int FETCH_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RESP = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: instruction-memory read port plus the fetch->decode handshake.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [DATA_W-1:0] imem_data;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  // Handshake: a transfer happens on a posedge where instr_valid && instr_ready.
  // While instr_valid is high and no transfer happens, instr/instr_pc stay stable.
  modport master (
    output imem_addr, imem_rd, instr, instr_pc, instr_valid,
    input  imem_data, instr_ready
  );

  modport slave (
    input  imem_addr, imem_rd, instr, instr_pc, instr_valid,
    output imem_data, instr_ready
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM and instruction register.
// Optional FETCH_CNT_EN adds a saturating count of completed handshakes.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [ADDR_W-1:0] last_add,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  fetch_unit_if.master      bus,
  output logic              halted,
  output fetch_state_e      dbg_state
`ifdef FETCH_CNT_EN
  ,output logic [FETCH_CNT_W-1:0] fetch_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              handshake;

  assign handshake = valid_q && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  // run=0 outranks redirect; redirect outranks the normal transition.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    if (!run) begin
      state_d = IDLE;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (redirect && state_q != IDLE) begin
      state_d = REQ;
      pc_d    = redirect_addr;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ:  state_d = RESP;
        RESP: begin
          instr_d    = bus.imem_data;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            valid_d = 1'b0;
            if (pc_q == last_add) begin
              state_d = HALT;
            end else begin
              pc_d    = pc_q + ADDR_W'(1);
              state_d = REQ;
            end
          end
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.imem_rd     = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign halted          = (state_q == HALT);
  assign dbg_state       = state_q;

`ifdef FETCH_CNT_EN
  logic [FETCH_CNT_W-1:0] count_q;

  // Only completed handshakes count; redirected fetches never raise valid.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count_q <= '0;
    end else if (handshake && count_q != '1) begin
      count_q <= count_q + FETCH_CNT_W'(1);
    end
  end

  assign fetch_count = count_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a 1-cycle-latency memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              reset, run, redirect;
  logic [ADDR_W-1:0] last_add, redirect_addr;
  logic              halted;
  fetch_state_e      dbg_state;
  logic [DATA_W-1:0] mem [256];
  int                vectors = 0;
  int                miscompares = 0;
`ifdef FETCH_CNT_EN
  logic [FETCH_CNT_W-1:0] fetch_count;
`endif

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk(clk), .reset(reset), .run(run), .last_add(last_add),
    .redirect(redirect), .redirect_addr(redirect_addr), .bus(bus),
    .halted(halted), .dbg_state(dbg_state)
`ifdef FETCH_CNT_EN
    ,.fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin step(); n++; end while (!bus.instr_valid && n < max);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; redirect = 1'b0; redirect_addr = '0;
    last_add = '0; bus.instr_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL rst_state got %0d expected %0d", dbg_state, IDLE); end
    vectors++; if (bus.imem_rd !== 1'b0) begin miscompares++; $display("FAIL rst_rd got %b expected 0", bus.imem_rd); end
    vectors++; if (bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_addr got %h expected 00", bus.imem_addr); end
    vectors++; if (bus.instr !== 8'h00 || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL rst_instr got %h/%h expected 00/00", bus.instr, bus.instr_pc); end
    vectors++; if (bus.instr_valid !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL rst_flags got %b/%b expected 0/0", bus.instr_valid, halted); end
    step();
    vectors++; if (dbg_state !== IDLE) begin miscompares++; $display("FAIL idle_hold got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_program();
    logic [7:0] prog [3];
    int n;
    prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56;
    last_add = 8'd2; bus.instr_ready = 1'b1; run = 1'b1;
    step();
    vectors++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h00) begin miscompares++; $display("FAIL prog_first_rd got %b@%h expected 1@00", bus.imem_rd, bus.imem_addr); end
    step();
    vectors++; if (bus.imem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL prog_resp got %b/%b expected 0/0", bus.imem_rd, bus.instr_valid); end
    step();
    vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== prog[0] || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL prog_i0 got %b %h@%h expected 1 %h@00", bus.instr_valid, bus.instr, bus.instr_pc, prog[0]); end
    for (int k = 1; k < 3; k++) begin
      wait_valid(8, n);
      vectors++; if (n !== 3) begin miscompares++; $display("FAIL prog_spacing%0d got %0d expected 3", k, n); end
      vectors++; if (bus.instr !== prog[k] || bus.instr_pc !== 8'(k)) begin miscompares++; $display("FAIL prog_i%0d got %h@%h expected %h@%h", k, bus.instr, bus.instr_pc, prog[k], 8'(k)); end
    end
    step();
    vectors++; if (halted !== 1'b1 || bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL prog_halt got %b/%b expected 1/0", halted, bus.instr_valid); end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++; if (bus.imem_rd !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL prog_halt_idle%0d got %b/%b expected 0/1", k, bus.imem_rd, halted); end
    end
`ifdef FETCH_CNT_EN
    vectors++; if (fetch_count !== 16'd3) begin miscompares++; $display("FAIL prog_count got %0d expected 3", fetch_count); end
`endif
    run = 1'b0; step();
  endtask

  task automatic test_stall();
    int n;
    last_add = 8'd2; bus.instr_ready = 1'b1; run = 1'b1;
    wait_valid(8, n);
    wait_valid(8, n);
    vectors++; if (bus.instr !== 8'h34 || n !== 3) begin miscompares++; $display("FAIL stall_pre got %h n=%0d expected 34 n=3", bus.instr, n); end
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      vectors++; if (bus.instr_valid !== 1'b1 || bus.instr !== 8'h34 || bus.instr_pc !== 8'h01 || bus.imem_rd !== 1'b0 || bus.imem_addr !== 8'h01) begin
        miscompares++; $display("FAIL stall_hold%0d got v%b %h@%h rd%b pc%h expected v1 34@01 rd0 pc01", k, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_rd, bus.imem_addr);
      end
    end
    bus.instr_ready = 1'b1;
    wait_valid(8, n);
    vectors++; if (bus.instr !== 8'h56 || bus.instr_pc !== 8'h02 || n !== 3) begin miscompares++; $display("FAIL stall_resume got %h@%h n=%0d expected 56@02 n=3", bus.instr, bus.instr_pc, n); end
    step();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL stall_halt got %b expected 1", halted); end
    run = 1'b0; step();
  endtask

  task automatic test_redirect_resp();
    int n;
    last_add = 8'h41; bus.instr_ready = 1'b1; run = 1'b1;
    wait_valid(8, n);
    step();
    vectors++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h01) begin miscompares++; $display("FAIL redir_req1 got %b@%h expected 1@01", bus.imem_rd, bus.imem_addr); end
    step();
    redirect = 1'b1; redirect_addr = 8'h40;
    step();
    redirect = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h40) begin miscompares++; $display("FAIL redir_req got v%b rd%b@%h expected v0 rd1@40", bus.instr_valid, bus.imem_rd, bus.imem_addr); end
    wait_valid(8, n);
    vectors++; if (n !== 2 || bus.instr_pc !== 8'h40 || bus.instr !== mem[8'h40]) begin miscompares++; $display("FAIL redir_first got %h@%h n=%0d expected %h@40 n=2", bus.instr, bus.instr_pc, n, mem[8'h40]); end
    wait_valid(8, n);
    vectors++; if (n !== 3 || bus.instr_pc !== 8'h41 || bus.instr !== mem[8'h41]) begin miscompares++; $display("FAIL redir_second got %h@%h n=%0d expected %h@41 n=3", bus.instr, bus.instr_pc, n, mem[8'h41]); end
    step();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL redir_halt got %b expected 1", halted); end
  endtask

  task automatic test_halt_redirect();
    int n;
    last_add = 8'h11; redirect = 1'b1; redirect_addr = 8'h10;
    step();
    redirect = 1'b0;
    vectors++; if (halted !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 8'h10) begin miscompares++; $display("FAIL hredir_req got h%b rd%b@%h expected h0 rd1@10", halted, bus.imem_rd, bus.imem_addr); end
    wait_valid(8, n);
    vectors++; if (n !== 2 || bus.instr_pc !== 8'h10 || bus.instr !== mem[8'h10]) begin miscompares++; $display("FAIL hredir_i0 got %h@%h n=%0d expected %h@10 n=2", bus.instr, bus.instr_pc, n, mem[8'h10]); end
    wait_valid(8, n);
    vectors++; if (n !== 3 || bus.instr_pc !== 8'h11 || bus.instr !== mem[8'h11]) begin miscompares++; $display("FAIL hredir_i1 got %h@%h n=%0d expected %h@11 n=3", bus.instr, bus.instr_pc, n, mem[8'h11]); end
    step();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL hredir_halt got %b expected 1", halted); end
  endtask

  task automatic test_wrap();
    logic [7:0] pcs [4];
    int n;
    pcs[0] = 8'hFE; pcs[1] = 8'hFF; pcs[2] = 8'h00; pcs[3] = 8'h01;
    last_add = 8'h01; redirect = 1'b1; redirect_addr = 8'hFE;
    step();
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(8, n);
      vectors++; if (n !== (k == 0 ? 2 : 3) || bus.instr_pc !== pcs[k] || bus.instr !== mem[pcs[k]]) begin
        miscompares++; $display("FAIL wrap_i%0d got %h@%h n=%0d expected %h@%h", k, bus.instr, bus.instr_pc, n, mem[pcs[k]], pcs[k]);
      end
    end
    step();
    vectors++; if (halted !== 1'b1 || bus.imem_addr !== 8'h01) begin miscompares++; $display("FAIL wrap_halt got h%b pc%h expected h1 pc01", halted, bus.imem_addr); end
    run = 1'b0; step();
  endtask

  task automatic test_last_zero();
    int n;
    last_add = 8'h00; bus.instr_ready = 1'b1; run = 1'b1;
    wait_valid(8, n);
    vectors++; if (n !== 3 || bus.instr !== 8'h12 || bus.instr_pc !== 8'h00) begin miscompares++; $display("FAIL lz_i0 got %h@%h n=%0d expected 12@00 n=3", bus.instr, bus.instr_pc, n); end
    step();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL lz_halt got %b expected 1", halted); end
    run = 1'b0; step();
  endtask

  task automatic test_run_drop();
    int n;
    last_add = 8'h05; bus.instr_ready = 1'b1; run = 1'b1;
    wait_valid(8, n);
    wait_valid(8, n);
    bus.instr_ready = 1'b0;
    step();
    vectors++; if (dbg_state !== HOLD || bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL drop_pre got %0d v%b expected %0d v1", dbg_state, bus.instr_valid, HOLD); end
`ifdef FETCH_CNT_EN
    vectors++; if (fetch_count !== 16'd1) begin miscompares++; $display("FAIL drop_count_pre got %0d expected 1", fetch_count); end
`endif
    run = 1'b0; redirect = 1'b1; redirect_addr = 8'h80;
    step();
    redirect = 1'b0;
    vectors++; if (dbg_state !== IDLE || bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h00 || halted !== 1'b0 || bus.imem_rd !== 1'b0) begin
      miscompares++; $display("FAIL drop_idle got s%0d v%b pc%h h%b rd%b expected s0 v0 pc00 h0 rd0", dbg_state, bus.instr_valid, bus.imem_addr, halted, bus.imem_rd);
    end
`ifdef FETCH_CNT_EN
    vectors++; if (fetch_count !== 16'd0) begin miscompares++; $display("FAIL drop_count got %0d expected 0", fetch_count); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 7);
    mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56;
    bus.imem_data = '0;
    test_reset();
    test_program();
    test_stall();
    test_last_zero();
    test_redirect_resp();
    test_halt_redirect();
    test_wrap();
    test_run_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction decoder/control unit.
- Owns the program counter and issues reads to the synchronous instruction memory (1-cycle read latency).
- Captures each returned byte into an instruction register and presents it to decode with a valid/ready handshake.
- Supports run/stop, halt at a programmable last address, and branch redirect.

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- DATA_W, 8, instruction width.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- run  input  1  enable; 0 forces IDLE with PC cleared.
- last_add  input  ADDR_W  address of final instruction; fetch halts after delivering it.
- redirect  input  1  branch/jump request, sampled on posedge.
- redirect_addr  input  ADDR_W  new PC when redirect=1.
- imem_addr  output  ADDR_W  read address to instruction memory.
- imem_rd  output  1  read strobe; memory returns data on imem_data the following cycle.
- imem_data  input  DATA_W  instruction byte from memory.
- instr  output  DATA_W  registered instruction to decoder.
- instr_pc  output  ADDR_W  address the current instr was fetched from.
- instr_valid  output  1  instr holds a valid instruction.
- instr_ready  input  1  decoder accepts instr this cycle.
- halted  output  1  high while in HALT.

Behaviour:
- Reset values: state IDLE, pc=0, imem_addr=0, imem_rd=0, instr=0, instr_pc=0, instr_valid=0, halted=0.
- Priority each posedge: reset > run=0 > redirect > normal transition.
- imem_rd=1 and imem_addr=pc exactly while state==REQ; otherwise imem_rd=0 and imem_addr holds pc.
- IDLE: if run=1, go to REQ.
- REQ: go to RESP.
- RESP: instr<=imem_data, instr_pc<=pc, instr_valid<=1, go to HOLD.
- HOLD: instr_valid=1, instr/instr_pc stable.
  - If instr_ready=1: instr_valid<=0.
  - Then if pc==last_add, go to HALT.
  - Else pc<=pc+1 (mod 2^ADDR_W) and go to REQ.
  - If instr_ready=0: stay in HOLD, all outputs stable.
- HALT: halted=1, no memory reads, instr_valid=0. Leaves only on redirect (to REQ) or run=0 (to IDLE).
- Latency: run rising to first imem_rd is 1 cycle; first instr_valid is 3 cycles after run is sampled high. Peak throughput is 1 instruction per 3 cycles with instr_ready tied high.
- Redirect (any state except IDLE):
  - pc<=redirect_addr, instr_valid<=0, go to REQ.
  - Any in-flight memory response is discarded (RESP data not captured).
  - Redirect in HOLD with instr_ready=1: the handshake completes (decoder has consumed instr); the PC increment is overridden by redirect_addr.
- run=0 in any state: go to IDLE, pc<=0, instr_valid<=0, halted<=0. A pending redirect is ignored.
- Wrap-around: pc 0xFF increments to 0x00. If last_add is below the redirected PC, fetch wraps and halts when pc==last_add. last_add=0 halts after the first instruction.
- last_add is sampled only in HOLD at handshake. Changing it mid-run affects the next comparison only.
- imem_data is ignored outside RESP.

Optional Feature:
- Macro FETCH_CNT_EN.
- Defined:
  - Adds output fetch_count (16 bits) counting completed handshakes (instr_valid && instr_ready).
  - Saturates at 0xFFFF.
  - Cleared by reset or run=0.
  - Not incremented by redirect-discarded fetches.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W/DATA_W constants.
  - fetch state enum (IDLE, REQ, RESP, HOLD, HALT).
  - FETCH_CNT_W=16.
- No sub-module; PC, FSM and instruction register are small enough to live in one module.

Test Plan:
- reset=1 for 2 cycles, run=1, last_add=2, memory {0x12,0x34,0x56}, instr_ready=1 → instr sequence 0x12/0x34/0x56 with instr_pc 0/1/2, valid pulses 3 cycles apart, then halted=1 and imem_rd stays 0.
- Same program, instr_ready=0 for 5 cycles on 0x34 → instr=0x34 and instr_valid held all 5 cycles, no imem_rd, pc stays 1; resumes to 0x56 after ready.
- Redirect=1, redirect_addr=0x40 asserted in RESP of addr 1 → memory byte at addr 1 never presented; next instr_pc=0x40.
- From HALT, redirect to 0x10 with last_add=0x11 → fetches 0x10, 0x11, then re-halts.
- redirect_addr=0xFE, last_add=0x01 → instr_pc sequence 0xFE, 0xFF, 0x00, 0x01, then halted.
- run dropped in HOLD → next cycle IDLE, instr_valid=0, pc=0; with FETCH_CNT_EN, fetch_count returns to 0.
